// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parser states, pop handshake
// states, error reason codes and the modulo-256 checksum adder.
package uart_pkg;

  // Frame parser position
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } rx_state_e;

  // Pop handshake. POP_FETCH is the strobe cycle. The cycle after it is
  // the wait, with fetch low, while the FIFO head advances.
  typedef enum logic {
    POP_READY = 1'b0,
    POP_FETCH = 1'b1
  } pop_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  // Running checksum wraps at 8 bits.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/fifo_popper.sv
// Owns the data/data_rdy/fetch handshake with the receive FIFO.
// It presents the head byte as a single-cycle strobe to the parser. A new
// byte is taken at most every other cycle so the FIFO head can advance.
module fifo_popper
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_rdy,
  output logic       fetch,
  output logic       byte_stb,
  output logic [7:0] byte_val
);

  pop_state_e pop_q;

  // The byte is consumed on the edge that raises fetch. The parser
  // registers its outputs on that same edge.
  assign byte_stb = (pop_q == POP_READY) && data_rdy;
  assign byte_val = data;
  assign fetch    = (pop_q == POP_FETCH);

  // Hold fetch for exactly one cycle per accepted byte, then re-arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_q <= POP_READY;
    end else if (byte_stb) begin
      pop_q <= POP_FETCH;
    end else begin
      pop_q <= POP_READY;
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind the UART receive FIFO. The frame format is
// SYNC, LEN, LEN payload bytes, CSUM.
// Payload bytes are streamed as they arrive. Each frame ends with a
// frame_ok or frame_err pulse, which downstream uses to commit or discard
// the payload.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC    = 8'h55,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_rdy,
  output logic       fetch,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int unsigned   TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);
  localparam logic [7:0]    MAX_L  = 8'(MAX_LEN);

  logic          take;
  logic [7:0]    rx_b;
  rx_state_e     state;
  logic [7:0]    remaining;
  logic [7:0]    sum;
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TO_LIM) ? v : v + TW'(1);
  endfunction

  fifo_popper u_popper (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .data_rdy (data_rdy),
    .fetch    (fetch),
    .byte_stb (take),
    .byte_val (rx_b)
  );

  // The timeout fires on the edge where the idle counter would reach
  // TIMEOUT. A byte arriving on that same edge takes priority.
  assign to_hit = (TIMEOUT != 0) && (state != ST_HUNT) && (sat_inc(to_cnt) == TO_LIM);

  // Parser FSM. All reported outputs are registered on the pop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HUNT;
      remaining <= 8'd0;
      sum       <= 8'd0;
      to_cnt    <= '0;
      out       <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (take || state == ST_HUNT) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= sat_inc(to_cnt);
      end

      if (take) begin
        case (state)
          ST_HUNT: begin
            if (rx_b == SYNC) begin
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_b == 8'd0 || rx_b > MAX_L) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= ST_HUNT;
            end else begin
              sum       <= rx_b;
              remaining <= rx_b;
              state     <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            sum       <= sum8(sum, rx_b);
            out       <= rx_b;
            out_valid <= 1'b1;
            out_last  <= (remaining == 8'd1);
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (sum8(sum, rx_b) == 8'd0) begin
              frame_ok <= 1'b1;
              err_code <= ERR_NONE;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
            state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end else if (to_hit) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= ST_HUNT;
      end
    end
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Consumer stage behind the receive FIFO of the UART path. It pops bytes through the same data/data_rdy/fetch handshake that uart_tx uses.
- Parses each frame: SYNC, LEN, LEN payload bytes, CSUM.
- Streams payload bytes downstream and reports, per frame, whether it was accepted or rejected.
- Runs entirely in the FIFO read-clock domain.

Parameters:
- SYNC, 8'h55, start-of-frame byte.
- MAX_LEN, 64, largest legal LEN value (1..255).
- TIMEOUT, 50000, max clk cycles allowed between byte pops inside a frame; 0 disables the timeout.

Ports:
- clk  input  1  FIFO read-side clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  8  FIFO head byte; valid while data_rdy=1.
- data_rdy  input  1  FIFO non-empty (level).
- fetch  output  1  one-cycle pop strobe to the FIFO.
- out  output  8  payload byte.
- out_valid  output  1  one-cycle strobe; out is valid in the same cycle.
- out_last  output  1  high with the out_valid of the final payload byte.
- frame_ok  output  1  one-cycle pulse: checksum matched.
- frame_err  output  1  one-cycle pulse: frame rejected.
- err_code  output  2  reason, held until the next frame_err: 0 none, 1 bad CSUM, 2 LEN=0 or LEN>MAX_LEN, 3 timeout.

Behaviour:
- Reset (asynchronous): every output is 0, the state is HUNT, and the counters and sum are cleared.
- Pop protocol:
  - When data_rdy=1 in a fetch-eligible cycle, the block samples data, asserts fetch for exactly that cycle, then spends one mandatory WAIT cycle with fetch=0 to let the FIFO advance its head.
  - Consequence: at most one pop every 2 clk cycles.
  - fetch is never asserted while data_rdy=0.
- States:
  - HUNT: pop a byte. If it equals SYNC, go to LEN; otherwise discard it and stay in HUNT. A non-SYNC byte never produces a frame_err.
  - LEN:
    - Pop L.
    - If L=0 or L>MAX_LEN: pulse frame_err, set err_code=2, go to HUNT.
    - Otherwise: sum<=L, remaining<=L, go to PAYLOAD.
  - PAYLOAD:
    - Pop b: sum<=sum+b (mod 256), and drive out=b with out_valid=1 in the pop cycle.
    - out_last=1 when remaining=1; decrement remaining.
    - After the last byte, go to CSUM.
  - CSUM:
    - Pop c.
    - If (sum+c) mod 256 = 0: pulse frame_ok.
    - Otherwise: pulse frame_err and set err_code=1.
    - Go to HUNT.
- Latency: out_valid, frame_ok and frame_err assert in the same cycle as the corresponding fetch (registered together).
- Payload bytes are never withheld. Downstream must commit or discard them on frame_ok/frame_err.
- Timeout:
  - A counter is cleared on every pop and increments each cycle while in LEN, PAYLOAD or CSUM.
  - When the counter reaches TIMEOUT: pulse frame_err, set err_code=3, go to HUNT. No out_last is emitted.
  - The counter is not active in HUNT.
- A SYNC value appearing inside the payload or in the CSUM position is treated as ordinary data; there is no resync.
- frame_ok and frame_err are mutually exclusive and fire at most once per frame.
- err_code is set to 0 on frame_ok.
- Reset mid-frame: the partial frame is dropped silently, with no frame_err.
- Counter widths:
  - remaining: 8 bits.
  - timeout counter: clog2(TIMEOUT+1) bits, saturating.

Decomposition:
- Shared package (uart_pkg):
  - state encoding (HUNT, LEN, PAYLOAD, CSUM, WAIT-return handling);
  - err_code constants ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TIMEOUT.
- Natural sub-module: fifo_popper, which owns the fetch/WAIT handshake and presents a one-cycle byte strobe to the parser FSM.

Test Plan:
- Good frame:
  - Stimulus: FIFO holds 55 03 10 20 30 9D.
  - Required: out_valid ×3 with out = 10, 20, 30; out_last on 30; frame_ok=1; err_code=0; exactly 6 fetch pulses, each separated by ≥1 idle cycle.
- Bad checksum:
  - Stimulus: 55 02 AA BB 00.
  - Required: out = AA, BB; frame_err=1; err_code=1; no frame_ok.
- Garbage then LEN errors:
  - Stimulus: 00 FF 55 00, then 55 41 (MAX_LEN=64).
  - Required: 00 and FF discarded silently; two frame_err pulses with err_code=2; no out_valid.
- Timeout:
  - Stimulus: 55 04 01, then the FIFO starves for TIMEOUT+5 cycles (TIMEOUT=100), then 55 01 07 F8 is delivered.
  - Required: out=01; frame_err with err_code=3 exactly 100 cycles after the 01 pop; the next frame then passes with frame_ok.
- Starved FIFO:
  - Stimulus: data_rdy toggles randomly during a valid frame 55 01 FF 00.
  - Required: fetch never asserted while data_rdy=0; frame_ok=1; out=FF with out_last.
- Async reset mid-payload:
  - Stimulus: rst asserted after 55 05 01 02.
  - Required: all outputs 0 immediately, without waiting for a clock edge; no frame_err; the following frame 55 01 0A F5 yields frame_ok.
